// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,output logic            ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a_sh, r_b_sh;
    logic [WIDTH-2:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_s, w_c, w_accept, w_last;

    assign w_s      = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_c      = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // r_res holds only the upper WIDTH-1 result bits; the final bit comes straight from the cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_res   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_res   <= (WIDTH-1)'({w_s, r_res} >> 1);
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= {w_s, r_res};
                r_cout <= w_c;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;
    // r_carry is the carry into the MSB while the last bit is processed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_ovf <= 1'b0;
        else if (w_last) r_ovf <= r_carry ^ w_c;
    end
    assign ovf = r_ovf;
`endif

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder: scoreboard queue of expected results, checked on done.
module tb_bit_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W:0] cs;
        logic       ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int   checks = 0, errors = 0, cyc = 0;
    exp_t sb[$];

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        exp_t e;
        e.cs = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
        e.ov = (ia[W-1] == ib[W-1]) && (e.cs[W-1] != ia[W-1]);
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 32'(sum), 32'(e.cs[W-1:0]));
            chk({tag, "_cout"}, 32'(cout), 32'(e.cs[W]));
`ifdef SERIAL_ADD_OVF_EN
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
`endif
        end
    endtask

    // Wait for done with a bound; returns edges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 3 * W) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Called at posedge+1 with the DUT idle; garbles operands during SHIFT.
    task automatic do_add(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic);
        int n;
        a = ia; b = ib; cin = ic; start = 1'b1;
        push_exp(ia, ib, ic);
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({tag, "_latency"}, 32'(n), 32'(W));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        pop_cmp(tag);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n, last;
        logic [W-1:0] held;

        // Reset state, before any clock edge
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_add("0f_01", 8'h0F, 8'h01, 1'b0);
        do_add("ff_01", 8'hFF, 8'h01, 1'b0);
        do_add("7f_00_c", 8'h7F, 8'h00, 1'b1);
        do_add("ff_ff_c", 8'hFF, 8'hFF, 1'b1);
        do_add("80_80", 8'h80, 8'h80, 1'b0);
        for (int i = 0; i < 4; i++)
            do_add("rand", W'($urandom), W'($urandom), 1'($urandom));

        // Result holds through idle cycles
        held = sum;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_sum", 32'(sum), 32'(held));

        // Start held high: back-to-back adds every W+2 cycles
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        last = 0;
        for (int rep = 0; rep < 3; rep++) begin
            push_exp(8'h01, 8'h02, 1'b0);
            @(posedge clk); #1;
            chk("bb_busy_acc", 32'(busy), 32'd1);
            a = W'($urandom); b = W'($urandom);
            wait_done(n);
            chk("bb_latency", 32'(n), 32'(W));
            if (rep > 0) chk("bb_period", 32'(cyc - last), 32'(W + 2));
            last = cyc;
            a = 8'h01; b = 8'h02;
            pop_cmp("bb");
            @(posedge clk); #1;
            chk("bb_idle", 32'(busy), 32'd0);
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Async reset while idle with a nonzero result held
        do_add("pre_rst", 8'h12, 8'h34, 1'b0);
        rst = 1'b1; #1;
        chk("idle_rst_sum", 32'(sum), 32'd0);
        chk("idle_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset at E4 of an in-flight add: discarded, no done pulse
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1; #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (done || busy) n++;
        end
        chk("mid_rst_quiet", 32'(n), 32'd0);

        do_add("post_rst", 8'h01, 8'h01, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
